// File: rtl/vga_capture.sv
// vga_capture: Gigatron video port receiver producing a pixel write stream.
// Optional sticky timing checker is built in when VGA_CAPTURE_CHECK_EN is defined.
module vga_capture #(
    parameter int H_BP     = 12,
    parameter int H_ACTIVE = 160,
    parameter int H_TOTAL  = 200,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [7:0]  i_out,
    input  logic        i_enable,
    output logic        o_pix_valid,
    output logic [7:0]  o_pix_x,
    output logic [8:0]  o_pix_y,
    output logic [5:0]  o_pix_rgb,
    output logic        o_frame_done,
    output logic        o_frame_abort,
    output logic [15:0] o_frame_count,
    output logic        o_busy,
    output logic        o_timing_err
);
    typedef enum logic [2:0] {SEEK, VBP, HBP, ACTIVE, HBLANK} state_t;

    localparam logic [7:0] HBP_LAST  = 8'(H_BP - 1);
    localparam logic [7:0] HACT_LAST = 8'(H_ACTIVE - 1);
    localparam logic [7:0] VBP_N     = 8'(V_BP);
    localparam logic [8:0] VACT_LAST = 9'(V_ACTIVE - 1);

    state_t      state, state_n;
    logic [7:0]  out_q;
    logic        vs_prev, hs_prev, vs_rise, hs_rise;
    logic [7:0]  cnt, cnt_n;
    logic [8:0]  y, y_n;
    logic        emit, done, abort, line_end;

    assign vs_rise = ~vs_prev & out_q[7];
    assign hs_rise = ~hs_prev & out_q[6];
    assign o_busy  = state != SEEK;

    // cnt is the VBP line counter, the HBP clock counter and the pixel column
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        y_n      = y;
        emit     = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        line_end = 1'b0;
        if (vs_rise) begin
            abort   = o_busy;
            state_n = i_enable ? VBP : SEEK;
            cnt_n   = '0;
        end else begin
            case (state)
                VBP:
                    if (hs_rise) begin
                        state_n = cnt == VBP_N ? HBP : VBP;
                        cnt_n   = cnt == VBP_N ? 8'd1 : cnt + 8'd1;
                        y_n     = '0;
                    end
                HBP:
                    if (hs_rise) line_end = 1'b1;
                    else begin
                        state_n = cnt == HBP_LAST ? ACTIVE : HBP;
                        cnt_n   = cnt == HBP_LAST ? 8'd0 : cnt + 8'd1;
                    end
                ACTIVE:
                    if (hs_rise) line_end = 1'b1;
                    else begin
                        emit    = 1'b1;
                        cnt_n   = cnt + 8'd1;
                        state_n = cnt == HACT_LAST ? HBLANK : ACTIVE;
                    end
                HBLANK: line_end = hs_rise;
                default: ;
            endcase
            if (line_end) begin
                done    = y == VACT_LAST;
                state_n = done ? SEEK : HBP;
                cnt_n   = 8'd1;
                y_n     = done ? y : y + 9'd1;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state         <= SEEK;
            out_q         <= 8'hC0;
            vs_prev       <= 1'b1;
            hs_prev       <= 1'b1;
            cnt           <= '0;
            y             <= '0;
            o_pix_valid   <= 1'b0;
            o_pix_x       <= '0;
            o_pix_y       <= '0;
            o_pix_rgb     <= '0;
            o_frame_done  <= 1'b0;
            o_frame_abort <= 1'b0;
            o_frame_count <= '0;
        end else begin
            state         <= state_n;
            out_q         <= i_out;
            vs_prev       <= out_q[7];
            hs_prev       <= out_q[6];
            cnt           <= cnt_n;
            y             <= y_n;
            o_pix_valid   <= emit;
            o_frame_done  <= done;
            o_frame_abort <= abort;
            if (emit) begin
                o_pix_x   <= cnt;
                o_pix_y   <= y;
                o_pix_rgb <= out_q[5:0];
            end
            if (done) o_frame_count <= o_frame_count + 16'd1;
        end
    end

`ifdef VGA_CAPTURE_CHECK_EN
    localparam logic [15:0] PERIOD = 16'(H_TOTAL);
    logic [15:0] pcnt;
    logic        pvalid, trunc;

    assign trunc = hs_rise & ~vs_rise & (state == HBP || state == ACTIVE);

    // a period is only judged once a previous hsync rise was seen while busy
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            pcnt         <= '0;
            pvalid       <= 1'b0;
            o_timing_err <= 1'b0;
        end else begin
            pcnt   <= hs_rise ? 16'd1 : pcnt + {15'd0, ~&pcnt};
            pvalid <= o_busy & (pvalid | hs_rise);
            if (trunc | abort | (o_busy & pvalid & hs_rise & (pcnt != PERIOD)))
                o_timing_err <= 1'b1;
        end
    end
`else
    assign o_timing_err = 1'b0;
`endif
endmodule
